// File: rtl/gaussian_blur_3x3.sv
// Streaming 3x3 Gaussian blur ([1 2 1; 2 4 2; 1 2 1] / 16) with two internal line buffers.
// Define GAUSS_ROUND_EN to round half up instead of truncating the final divide.
module gaussian_blur_3x3 #(
   parameter int WIDTH = 8,
   parameter int H_RES = 320
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_vsync,
   input  logic             i_hsync,
   input  logic             i_de,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_vsync,
   output logic             o_hsync,
   output logic             o_de,
   output logic [WIDTH-1:0] o_data
);

   localparam int XW = $clog2(H_RES + 1);
   localparam int AW = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int SW = WIDTH + 4;
   localparam logic [XW-1:0] X_MAX = XW'(H_RES);

   logic [2:0]       vs_d;
   logic [2:0]       hs_d;
   logic [2:0]       de_d;

   logic [XW-1:0]    x;
   logic [1:0]       y;
   logic             accept;
   logic             vs_rise;
   logic             de_fall;
   logic [AW-1:0]    addr;

   logic [WIDTH-1:0] lb0 [0:H_RES-1];
   logic [WIDTH-1:0] lb1 [0:H_RES-1];
   logic [WIDTH-1:0] lb0_rd;
   logic [WIDTH-1:0] lb1_rd;

   logic [WIDTH-1:0] win [0:2][0:2];
   logic             valid1;
   logic             valid2;
   logic [SW-1:0]    row_top;
   logic [SW-1:0]    row_mid;
   logic [SW-1:0]    row_bot;
   logic [SW-1:0]    total;
   logic [WIDTH-1:0] result;

   function automatic logic [SW-1:0] ext(input logic [WIDTH-1:0] v);
      return SW'(v);
   endfunction

   // A pixel beyond H_RES is ignored entirely: no buffer write and no window shift.
   assign accept  = i_de && (x < X_MAX);
   assign vs_rise = i_vsync && !vs_d[0];
   assign de_fall = de_d[0] && !i_de;
   assign addr    = x[AW-1:0];
   assign lb0_rd  = lb0[addr];
   assign lb1_rd  = lb1[addr];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vs_d <= '0;
         hs_d <= '0;
         de_d <= '0;
      end else begin
         vs_d <= {vs_d[1:0], i_vsync};
         hs_d <= {hs_d[1:0], i_hsync};
         de_d <= {de_d[1:0], i_de};
      end
   end

   assign o_vsync = vs_d[2];
   assign o_hsync = hs_d[2];
   assign o_de    = de_d[2];

   // Any de-low cycle ends the line; y only needs to know whether two lines are buffered.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         x <= '0;
         y <= '0;
      end else begin
         if (!i_de) begin
            x <= '0;
         end else if (x != X_MAX) begin
            x <= x + 1'b1;
         end
         if (vs_rise) begin
            y <= '0;
         end else if (de_fall && (y != 2'd2)) begin
            y <= y + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         lb1[addr] <= lb0_rd;
         lb0[addr] <= i_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               win[r][c] <= '0;
            end
         end
         valid1 <= 1'b0;
      end else begin
         if (accept) begin
            for (int r = 0; r < 3; r++) begin
               win[r][0] <= win[r][1];
               win[r][1] <= win[r][2];
            end
            win[0][2] <= lb1_rd;
            win[1][2] <= lb0_rd;
            win[2][2] <= i_data;
         end
         valid1 <= accept && (x >= XW'(2)) && (y == 2'd2);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         row_top <= '0;
         row_mid <= '0;
         row_bot <= '0;
         valid2  <= 1'b0;
      end else begin
         row_top <= ext(win[0][0]) + (ext(win[0][1]) << 1) + ext(win[0][2]);
         row_mid <= (ext(win[1][0]) << 1) + (ext(win[1][1]) << 2) + (ext(win[1][2]) << 1);
         row_bot <= ext(win[2][0]) + (ext(win[2][1]) << 1) + ext(win[2][2]);
         valid2  <= valid1;
      end
   end

   // Max total is 16 * (2^WIDTH - 1) plus the rounding bias, so the quotient always fits WIDTH bits.
   always_comb begin
`ifdef GAUSS_ROUND_EN
      total = row_top + row_mid + row_bot + SW'(8);
`else
      total = row_top + row_mid + row_bot;
`endif
      result = WIDTH'(total >> 4);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         o_data <= '0;
      end else begin
         o_data <= (valid2 && de_d[1]) ? result : '0;
      end
   end

endmodule

// File: tb/tb_gaussian_blur_3x3.sv
// Scoreboard bench for gaussian_blur_3x3 (H_RES=8) with hand-computed expected rows.
// Honours GAUSS_ROUND_EN for the impulse response values.
module tb_gaussian_blur_3x3;

   localparam int WIDTH = 8;
   localparam int H_RES = 8;

`ifdef GAUSS_ROUND_EN
   localparam logic [7:0] W4 = 8'd64;
   localparam logic [7:0] W2 = 8'd32;
   localparam logic [7:0] W1 = 8'd16;
`else
   localparam logic [7:0] W4 = 8'd63;
   localparam logic [7:0] W2 = 8'd31;
   localparam logic [7:0] W1 = 8'd15;
`endif

   typedef struct {
      logic [7:0] data;
      int         row;
      int         col;
   } exp_t;

   logic             clk = 1'b0;
   logic             rstn;
   logic             i_vsync;
   logic             i_hsync;
   logic             i_de;
   logic [WIDTH-1:0] i_data;
   logic             o_vsync;
   logic             o_hsync;
   logic             o_de;
   logic [WIDTH-1:0] o_data;

   exp_t       expQ[$];
   int         checks = 0;
   int         errors = 0;
   int         rowTag = 0;
   logic [7:0] pix [0:15];
   logic [7:0] expRow [0:15];
   logic [2:0] vsHist;
   logic [2:0] hsHist;
   logic [2:0] deHist;

   gaussian_blur_3x3 #(.WIDTH(WIDTH), .H_RES(H_RES)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .i_vsync (i_vsync),
      .i_hsync (i_hsync),
      .i_de    (i_de),
      .i_data  (i_data),
      .o_vsync (o_vsync),
      .o_hsync (o_hsync),
      .o_de    (o_de),
      .o_data  (o_data)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic vs, input logic hs, input logic de,
                                input logic [7:0] d, input logic [7:0] e, input int col);
      @(posedge clk);
      #1;
      i_vsync = vs;
      i_hsync = hs;
      i_de    = de;
      i_data  = d;
      if (de) expQ.push_back('{data: e, row: rowTag, col: col});
   endtask

   task automatic setLine(input logic [7:0] v, input logic [7:0] e);
      for (int c = 0; c < 16; c++) begin
         pix[c]    = v;
         expRow[c] = (c >= 2 && c < H_RES) ? e : 8'd0;
      end
   endtask

   task automatic sendLine(input int len);
      for (int c = 0; c < len; c++) applyStimulus(1'b0, 1'b0, 1'b1, pix[c], expRow[c], c);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 0);
      rowTag++;
   endtask

   task automatic vsyncGap();
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 0);
      rowTag = 0;
   endtask

   // Reference sync timing: each output sync is its input three clocks earlier.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vsHist <= '0;
         hsHist <= '0;
         deHist <= '0;
      end else begin
         vsHist <= {vsHist[1:0], i_vsync};
         hsHist <= {hsHist[1:0], i_hsync};
         deHist <= {deHist[1:0], i_de};
      end
   end

   always @(negedge clk) begin
      if (!rstn) begin
         checkOutput("outputs in reset", {o_vsync, o_hsync, o_de, o_data}, 32'd0);
      end else begin
         checkOutput("sync delay {vs,hs,de}", {o_vsync, o_hsync, o_de}, {vsHist[2], hsHist[2], deHist[2]});
      end
   end

   // Scoreboard monitor: every presented pixel consumes one expected entry.
   always @(negedge clk) begin
      exp_t e;
      if (rstn) begin
         if (o_de) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected output: got data %0d with empty queue", o_data);
            end else begin
               e = expQ.pop_front();
               checkOutput($sformatf("data r%0d c%0d", e.row, e.col), o_data, e.data);
            end
         end else begin
            checkOutput("o_data while de low", o_data, 32'd0);
         end
      end
   end

   initial begin
      rstn    = 1'b0;
      i_vsync = 1'b0;
      i_hsync = 1'b0;
      i_de    = 1'b0;
      i_data  = '0;

      // Inputs toggle while reset is held; outputs must stay at zero.
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         i_vsync = 1'($urandom);
         i_hsync = 1'($urandom);
         i_de    = 1'($urandom);
         i_data  = 8'($urandom);
      end
      @(posedge clk);
      #1;
      i_vsync = 1'b0;
      i_hsync = 1'b0;
      i_de    = 1'b0;
      i_data  = '0;
      rstn    = 1'b1;

      // Short irregular de bursts right after release, all outputs zero.
      applyStimulus(1'b0, 1'b0, 1'b1, 8'd55, 8'd0, 0);
      applyStimulus(1'b0, 1'b1, 1'b1, 8'd66, 8'd0, 1);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'd77, 8'd0, 2);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'd88, 8'd0, 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'd99, 8'd0, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 0);

      // Constant frame of 100, then a mid-frame vsync followed by 40/80/120 lines.
      vsyncGap();
      setLine(8'd100, 8'd0);
      sendLine(H_RES);
      sendLine(H_RES);
      setLine(8'd100, 8'd100);
      sendLine(H_RES);
      sendLine(H_RES);
      vsyncGap();
      setLine(8'd40, 8'd0);
      sendLine(H_RES);
      setLine(8'd80, 8'd0);
      sendLine(H_RES);
      setLine(8'd120, 8'd80);
      sendLine(H_RES);

      // Impulse of 255 at column 3, row 1 of a 5-line frame.
      vsyncGap();
      setLine(8'd0, 8'd0);
      sendLine(H_RES);
      pix[3] = 8'd255;
      sendLine(H_RES);
      setLine(8'd0, 8'd0);
      expRow[3] = W2;
      expRow[4] = W4;
      expRow[5] = W2;
      sendLine(H_RES);
      setLine(8'd0, 8'd0);
      expRow[3] = W1;
      expRow[4] = W2;
      expRow[5] = W1;
      sendLine(H_RES);
      setLine(8'd0, 8'd0);
      sendLine(H_RES);

      // Full scale must not wrap.
      vsyncGap();
      setLine(8'd255, 8'd0);
      sendLine(H_RES);
      sendLine(H_RES);
      setLine(8'd255, 8'd255);
      sendLine(H_RES);
      sendLine(H_RES);

      // Overlong line: three extra 240 pixels must neither output nor corrupt the buffers.
      vsyncGap();
      setLine(8'd16, 8'd0);
      sendLine(H_RES);
      setLine(8'd32, 8'd0);
      sendLine(H_RES);
      setLine(8'd48, 8'd32);
      pix[8]  = 8'd240;
      pix[9]  = 8'd240;
      pix[10] = 8'd240;
      sendLine(H_RES + 3);
      setLine(8'd64, 8'd48);
      sendLine(H_RES);
      setLine(8'd80, 8'd64);
      sendLine(H_RES);

      // Reset in the middle of a valid row, then two zero rows before valid data returns.
      vsyncGap();
      setLine(8'd90, 8'd0);
      sendLine(H_RES);
      sendLine(H_RES);
      setLine(8'd90, 8'd90);
      for (int c = 0; c < 5; c++) applyStimulus(1'b0, 1'b0, 1'b1, pix[c], expRow[c], c);
      @(posedge clk);
      #2;
      rstn = 1'b0;
      #1;
      checkOutput("async reset drop", {o_vsync, o_hsync, o_de, o_data}, 32'd0);
      expQ.delete();
      i_de   = 1'b0;
      i_data = '0;
      repeat (3) @(posedge clk);
      #1;
      rstn   = 1'b1;
      rowTag = 0;
      setLine(8'd90, 8'd0);
      sendLine(H_RES);
      sendLine(H_RES);
      setLine(8'd90, 8'd90);
      sendLine(H_RES);

      for (int i = 0; i < 50 && expQ.size() != 0; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      checkOutput("scoreboard drained", expQ.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
